// File: rtl/core_mem_resp_if.sv
// Core request bus between cache control (master) and the core-memory responder (slave).
// CORE_PARITY_EN adds the write-parity input and the read-parity / parity-error outputs.
interface core_mem_resp_if;
  logic        core_rd_rq_l;
  logic        core_wr_rq_l;
  logic        one_word_rd_h;
  logic        one_word_wr_h;
  logic [21:0] core_adr_h;
  logic [35:0] core_wr_data_h;
  logic        core_busy_h;
  logic        core_busy_l;
  logic        core_data_valid_h;
  logic        core_data_valid_l;
  logic        core_wr_ack_h;
  logic [1:0]  core_word_sel_h;
  logic [35:0] core_rd_data_h;
  logic        core_proto_err_h;
`ifdef CORE_PARITY_EN
  logic        core_wr_par_h;
  logic        core_rd_par_h;
  logic        core_par_err_h;

  modport master (
    output core_rd_rq_l, core_wr_rq_l, one_word_rd_h, one_word_wr_h,
           core_adr_h, core_wr_data_h, core_wr_par_h,
    input  core_busy_h, core_busy_l, core_data_valid_h, core_data_valid_l,
           core_wr_ack_h, core_word_sel_h, core_rd_data_h, core_proto_err_h,
           core_rd_par_h, core_par_err_h
  );

  modport slave (
    input  core_rd_rq_l, core_wr_rq_l, one_word_rd_h, one_word_wr_h,
           core_adr_h, core_wr_data_h, core_wr_par_h,
    output core_busy_h, core_busy_l, core_data_valid_h, core_data_valid_l,
           core_wr_ack_h, core_word_sel_h, core_rd_data_h, core_proto_err_h,
           core_rd_par_h, core_par_err_h
  );
`else
  modport master (
    output core_rd_rq_l, core_wr_rq_l, one_word_rd_h, one_word_wr_h,
           core_adr_h, core_wr_data_h,
    input  core_busy_h, core_busy_l, core_data_valid_h, core_data_valid_l,
           core_wr_ack_h, core_word_sel_h, core_rd_data_h, core_proto_err_h
  );

  modport slave (
    input  core_rd_rq_l, core_wr_rq_l, one_word_rd_h, one_word_wr_h,
           core_adr_h, core_wr_data_h,
    output core_busy_h, core_busy_l, core_data_valid_h, core_data_valid_l,
           core_wr_ack_h, core_word_sel_h, core_rd_data_h, core_proto_err_h
  );
`endif
endinterface

// File: rtl/core_mem_resp.sv
// Core-memory responder: accepts core read/write bursts and serves them from a backing word array.
// Define CORE_PARITY_EN to store an odd-parity bit per word and flag even-parity writes.
module core_mem_resp #(
  parameter int MEM_WORDS     = 4096,
  parameter int ACCESS_CYCLES = 4,
  parameter int WORD_GAP      = 1
) (
  input  logic           clk_mbox_h,
  input  logic           mr_reset_h,
  core_mem_resp_if.slave bus
);

  localparam int DATA_W = 36;
`ifdef CORE_PARITY_EN
  localparam int MEM_W  = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
`endif
  localparam int AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_MAX = (ACCESS_CYCLES > WORD_GAP) ? ACCESS_CYCLES : WORD_GAP;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_XFER, S_RECOVER} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         left_q, left_d;
  logic [1:0]         nxt_sel_q, nxt_sel_d;
  logic [1:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               ack_q, ack_d;
  logic               proto_err_q, proto_err_d;
  logic               is_wr_q, is_wr_d;
  logic [19:0]        adr_hi_q, adr_hi_d;
  logic [DATA_W-1:0]  rd_data_q;
  logic               emit;
  logic [AW-1:0]      emit_idx;
  logic [AW-1:0]      wr_idx;
  logic [MEM_W-1:0]   mem_rd;
  logic [MEM_W-1:0]   wr_word;

  logic [MEM_W-1:0]   mem_q [MEM_WORDS];

  // Word address = {latched quad address, word-in-quad}, folded into the array.
  function automatic logic [AW-1:0] word_idx(input logic [19:0] hi, input logic [1:0] sel);
    logic [21:0] wa;
    wa = {hi, sel};
    return AW'(wa % 22'(MEM_WORDS));
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    nxt_sel_d   = nxt_sel_q;
    sel_d       = sel_q;
    is_wr_d     = is_wr_q;
    adr_hi_d    = adr_hi_q;
    proto_err_d = proto_err_q;
    valid_d     = 1'b0;
    ack_d       = 1'b0;
    emit        = 1'b0;
    emit_idx    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.core_rd_rq_l || !bus.core_wr_rq_l) begin
          // A read request takes priority when both are asserted.
          is_wr_d   = bus.core_rd_rq_l;
          adr_hi_d  = bus.core_adr_h[21:2];
          nxt_sel_d = bus.core_adr_h[1:0];
          if (!bus.core_rd_rq_l)
            left_d = bus.one_word_rd_h ? 3'd1 : 3'd4;
          else
            left_d = bus.one_word_wr_h ? 3'd1 : 3'd4;
          if (!bus.core_rd_rq_l && !bus.core_wr_rq_l)
            proto_err_d = 1'b1;
          cnt_d = CNT_W'(ACCESS_CYCLES - 1);
          if (ACCESS_CYCLES == 1) begin
            state_d = S_XFER;
            emit    = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_XFER;
          emit    = 1'b1;
        end
      end
      S_XFER: begin
        if (left_q == 3'd0)
          state_d = S_RECOVER;
        else if (cnt_q == '0)
          emit = 1'b1;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Strobes are registered, so a word decided here appears on the bus next cycle.
    if (emit) begin
      valid_d   = !is_wr_d;
      ack_d     = is_wr_d;
      sel_d     = nxt_sel_d;
      emit_idx  = word_idx(adr_hi_d, nxt_sel_d);
      nxt_sel_d = nxt_sel_d + 2'd1;
      left_d    = left_d - 3'd1;
      cnt_d     = CNT_W'(WORD_GAP - 1);
    end
  end

  assign mem_rd = mem_q[emit_idx];
  assign wr_idx = word_idx(adr_hi_q, sel_q);
`ifdef CORE_PARITY_EN
  assign wr_word = {bus.core_wr_par_h, bus.core_wr_data_h};
`else
  assign wr_word = bus.core_wr_data_h;
`endif

  always_ff @(posedge clk_mbox_h) begin
    if (mr_reset_h) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      nxt_sel_q   <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      proto_err_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      nxt_sel_q   <= nxt_sel_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      proto_err_q <= proto_err_d;
      if (emit && !is_wr_d)
        rd_data_q <= mem_rd[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_mbox_h) begin
    is_wr_q  <= is_wr_d;
    adr_hi_q <= adr_hi_d;
  end

  // The write lands at the end of the ack cycle; a reset on that edge cancels it.
  always_ff @(posedge clk_mbox_h) begin
    if (ack_q && !mr_reset_h)
      mem_q[wr_idx] <= wr_word;
  end

`ifdef CORE_PARITY_EN
  logic rd_par_q;
  logic par_err_q;

  always_ff @(posedge clk_mbox_h) begin
    if (mr_reset_h) begin
      rd_par_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (emit && !is_wr_d)
        rd_par_q <= mem_rd[DATA_W];
      if (ack_q && !(^wr_word))
        par_err_q <= 1'b1;
    end
  end

  assign bus.core_rd_par_h  = rd_par_q;
  assign bus.core_par_err_h = par_err_q;
`endif

  assign bus.core_busy_h       = (state_q != S_IDLE);
  assign bus.core_busy_l       = (state_q == S_IDLE);
  assign bus.core_data_valid_h = valid_q;
  assign bus.core_data_valid_l = ~valid_q;
  assign bus.core_wr_ack_h     = ack_q;
  assign bus.core_word_sel_h   = sel_q;
  assign bus.core_rd_data_h    = rd_data_q;
  assign bus.core_proto_err_h  = proto_err_q;

endmodule

// File: tb/tb_core_mem_resp.sv
// Directed bench for core_mem_resp: bursts, latency, protocol error, mid-burst reset, word gap.
// With CORE_PARITY_EN defined it also exercises the parity ports.
module tb_core_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  core_mem_resp_if ifa();
  core_mem_resp_if ifb();

  core_mem_resp #(.MEM_WORDS(4096), .ACCESS_CYCLES(4), .WORD_GAP(1)) dut_a (
    .clk_mbox_h (clk),
    .mr_reset_h (rst),
    .bus        (ifa)
  );

  core_mem_resp #(.MEM_WORDS(64), .ACCESS_CYCLES(4), .WORD_GAP(3)) dut_b (
    .clk_mbox_h (clk),
    .mr_reset_h (rst),
    .bus        (ifb)
  );

  int          nv, nack, busy_rise, busy_fall, compl_err;
  int          v_cyc [4];
  int          a_cyc [4];
  logic [35:0] v_dat [4];
  logic [1:0]  v_sel [4];
  logic [1:0]  a_sel [4];
  logic [35:0] wq    [4];
  logic [35:0] exp_d [4];
  logic [1:0]  exp_s [4];
  logic        bad_par = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic drive_wdata(input int idx);
    ifa.core_wr_data_h = wq[idx];
`ifdef CORE_PARITY_EN
    ifa.core_wr_par_h = (~^wq[idx]) ^ bad_par;
`endif
  endtask

  // Issue one request on dut_a in the current cycle (cycle 0) and log strobes until busy drops.
  task automatic req_a(input bit rd, input bit wr, input bit one, input logic [21:0] adr,
                       input int rst_ack);
    nv = 0; nack = 0; busy_rise = -1; busy_fall = -1; compl_err = 0;
    ifa.core_adr_h    = adr;
    ifa.one_word_rd_h = one;
    ifa.one_word_wr_h = one;
    ifa.core_rd_rq_l  = !rd;
    ifa.core_wr_rq_l  = !wr;
    drive_wdata(0);
    tick();
    ifa.core_rd_rq_l = 1'b1;
    ifa.core_wr_rq_l = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      drive_wdata(nack < 4 ? nack : 3);
      if (ifa.core_busy_l !== ~ifa.core_busy_h || ifa.core_data_valid_l !== ~ifa.core_data_valid_h)
        compl_err++;
      if (ifa.core_busy_h === 1'b1 && busy_rise < 0)
        busy_rise = c;
      if (ifa.core_data_valid_h === 1'b1) begin
        if (nv < 4) begin
          v_cyc[nv] = c;
          v_dat[nv] = ifa.core_rd_data_h;
          v_sel[nv] = ifa.core_word_sel_h;
        end
        nv++;
      end
      if (ifa.core_wr_ack_h === 1'b1) begin
        if (nack < 4) begin
          a_cyc[nack] = c;
          a_sel[nack] = ifa.core_word_sel_h;
        end
        nack++;
        if (nack == rst_ack)
          rst = 1'b1;
      end
      if (busy_rise > 0 && ifa.core_busy_h !== 1'b1) begin
        busy_fall = c;
        break;
      end
      tick();
      rst = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy_h"},  ifa.core_busy_h, 1'b0);
    chk({pfx, "_busy_l"},  ifa.core_busy_l, 1'b1);
    chk({pfx, "_valid_h"}, ifa.core_data_valid_h, 1'b0);
    chk({pfx, "_valid_l"}, ifa.core_data_valid_l, 1'b1);
    chk({pfx, "_wr_ack"},  ifa.core_wr_ack_h, 1'b0);
    chk({pfx, "_sel"},     ifa.core_word_sel_h, 2'd0);
    chk({pfx, "_rd_data"}, ifa.core_rd_data_h, 36'o0);
    chk({pfx, "_proto"},   ifa.core_proto_err_h, 1'b0);
  endtask

  initial begin
    int nbv, first_idle, strobes;
    int bv [8];
    int exp_bv [8];
    logic busy16;

    rst = 1'b1;
    ifa.core_rd_rq_l = 1'b1; ifa.core_wr_rq_l = 1'b1;
    ifa.one_word_rd_h = 1'b0; ifa.one_word_wr_h = 1'b0;
    ifa.core_adr_h = '0; ifa.core_wr_data_h = '0;
    ifb.core_rd_rq_l = 1'b1; ifb.core_wr_rq_l = 1'b1;
    ifb.one_word_rd_h = 1'b0; ifb.one_word_wr_h = 1'b0;
    ifb.core_adr_h = '0; ifb.core_wr_data_h = '0;
`ifdef CORE_PARITY_EN
    ifa.core_wr_par_h = 1'b1;
    ifb.core_wr_par_h = 1'b1;
`endif
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Fill words 0o100..0o103 with their own addresses.
    wq = '{36'o100, 36'o101, 36'o102, 36'o103};
    req_a(1'b0, 1'b1, 1'b0, 22'o100, 0);
    chk("fill_nack", nack, 4);
    chk("fill_ack0_cyc", a_cyc[0], 4);
    chk("fill_ack3_sel", a_sel[3], 2'd3);
    chk("fill_busy_fall", busy_fall, 9);

    // Four-word read starting mid-quad: wraps 2,3,0,1.
    req_a(1'b1, 1'b0, 1'b0, 22'o102, 0);
    exp_d = '{36'o102, 36'o103, 36'o100, 36'o101};
    exp_s = '{2'd2, 2'd3, 2'd0, 2'd1};
    chk("rd4_nv", nv, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd4_cyc%0d", k), v_cyc[k], 4 + k);
      chk($sformatf("rd4_dat%0d", k), v_dat[k], exp_d[k]);
      chk($sformatf("rd4_sel%0d", k), v_sel[k], exp_s[k]);
    end
    chk("rd4_busy_rise", busy_rise, 1);
    chk("rd4_busy_fall", busy_fall, 9);
    chk("rd4_compl", compl_err, 0);
    chk("rd4_hold", ifa.core_rd_data_h, 36'o101);
    chk("rd4_proto", ifa.core_proto_err_h, 1'b0);

    // One-word write then one-word read at address 5.
    wq[0] = 36'o123456701234;
    req_a(1'b0, 1'b1, 1'b1, 22'd5, 0);
    chk("wr1_nack", nack, 1);
    chk("wr1_ack_cyc", a_cyc[0], 4);
    chk("wr1_sel", a_sel[0], 2'd1);
    chk("wr1_busy_fall", busy_fall, 6);
    req_a(1'b1, 1'b0, 1'b1, 22'd5, 0);
    chk("rd1_nv", nv, 1);
    chk("rd1_dat", v_dat[0], 36'o123456701234);
    chk("rd1_nack", nack, 0);
    chk("rd1_busy_fall", busy_fall, 6);

    // Read and write requested together: the read runs, error sticks.
    req_a(1'b1, 1'b1, 1'b0, 22'o100, 0);
    chk("both_nv", nv, 4);
    chk("both_nack", nack, 0);
    chk("both_dat0", v_dat[0], 36'o100);
    chk("both_dat3", v_dat[3], 36'o103);
    chk("both_proto", ifa.core_proto_err_h, 1'b1);
    repeat (3) tick();
    chk("both_proto_sticky", ifa.core_proto_err_h, 1'b1);

    // Reset during the third word of a write burst.
    wq = '{36'o7000, 36'o7001, 36'o7002, 36'o7003};
    req_a(1'b0, 1'b1, 1'b0, 22'o200, 0);
    chk("pre_nack", nack, 4);
    wq = '{36'o1111, 36'o2222, 36'o3333, 36'o4444};
    req_a(1'b0, 1'b1, 1'b0, 22'o200, 3);
    chk("abort_nack", nack, 3);
    chk("abort_fall", busy_fall, 7);
    chk_reset_outputs("abort");
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ifa.core_wr_ack_h !== 1'b0 || ifa.core_data_valid_h !== 1'b0 || ifa.core_busy_h !== 1'b0)
        strobes++;
    end
    chk("abort_quiet", strobes, 0);
    req_a(1'b1, 1'b0, 1'b0, 22'o200, 0);
    exp_d = '{36'o1111, 36'o2222, 36'o7002, 36'o7003};
    chk("abort_rd_nv", nv, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("abort_rd_dat%0d", k), v_dat[k], exp_d[k]);

    // dut_b (WORD_GAP=3): request held low across the first burst.
    exp_bv = '{4, 7, 10, 13, 19, 22, 25, 28};
    for (int k = 0; k < 8; k++) bv[k] = -1;
    nbv = 0; first_idle = -1; busy16 = 1'b0;
    ifb.core_rd_rq_l = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (ifb.core_data_valid_h === 1'b1) begin
        if (nbv < 8) bv[nbv] = c;
        nbv++;
      end
      if (ifb.core_busy_h !== 1'b1 && first_idle < 0)
        first_idle = c;
      if (c == 16) begin
        busy16 = ifb.core_busy_h;
        ifb.core_rd_rq_l = 1'b1;
      end
    end
    chk("b2b_nv", nbv, 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("b2b_cyc%0d", k), bv[k], exp_bv[k]);
    chk("b2b_first_idle", first_idle, 15);
    chk("b2b_busy16", busy16, 1'b1);

`ifdef CORE_PARITY_EN
    chk("par_err_clear", ifa.core_par_err_h, 1'b0);
    bad_par = 1'b1;
    wq[0] = 36'o17;
    req_a(1'b0, 1'b1, 1'b1, 22'd6, 0);
    bad_par = 1'b0;
    chk("par_err_set", ifa.core_par_err_h, 1'b1);
    req_a(1'b1, 1'b0, 1'b1, 22'd6, 0);
    chk("par_rd_dat", v_dat[0], 36'o17);
    chk("par_rd_par", ifa.core_rd_par_h, 1'b0);
    chk("par_err_sticky", ifa.core_par_err_h, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
